reg_cmd_master: RTL and testbench
=================================

// Module: reg_cmd_master
// PURPOSE
//  Host-side initiator for the register-access byte protocol: converts one local
//  register read/write request into the 8-byte command stream (0xAA, type, addr[2],
//  data[4]) and collects the 4-byte little-endian reply. Sits between a local
//  controller (sequencer/bridge/bench) and a byte link toward a register responder.
//  One transaction in flight; no queuing.
// PARAMETERS
//  TIMEOUT  1000  reply-phase idle limit in clk cycles (1..65535); 0 disables timeout
// PORTS
//  clk_i        in   1   clock; all logic on rising edge
//  reset_i      in   1   reset, asynchronous, active-high
//  req_i        in   1   request strobe; sampled only in IDLE
//  req_wr_i     in   1   1=write, 0=read (type byte bit0)
//  req_addr_i   in   16  register address
//  req_data_i   in   32  write data (sent also for reads)
//  busy_o       out  1   transaction in progress
//  done_o       out  1   1-cycle pulse: reply complete, rd_data_o valid
//  err_o        out  1   1-cycle pulse: reply timeout, transaction abandoned
//  rd_data_o    out  32  assembled reply word; held until next done_o
//  out_data_o   out  8   command byte to link
//  out_valid_o  out  1   out_data_o valid
//  out_rdy_i    in   1   link accepts byte on edge where out_valid_o && out_rdy_i
//  in_rdy_i     in   1   reply byte strobe, one byte per high cycle
//  in_data_i    in   8   reply byte
// BEHAVIOUR
//  Reset (async): state IDLE; busy_o, done_o, err_o, out_valid_o = 0;
//   out_data_o = 8'h00; rd_data_o = 32'h0; byte index and timeout counter = 0.
//  Reset mid-transaction aborts immediately; no done_o/err_o pulse; link sees
//   out_valid_o drop asynchronously.
//  States: IDLE -> SEND -> RECV -> IDLE (done_o or err_o emitted on exit).
//  IDLE: on edge with req_i=1, latch wr/addr/data, go SEND, idx=0, busy_o=1.
//   req_i while busy_o=1 ignored (not queued, no error).
//  SEND: out_valid_o=1; out_data_o by idx: 0:8'hAA 1:{7'b0,wr} 2:addr[7:0]
//   3:addr[15:8] 4:data[7:0] 5:data[15:8] 6:data[23:16] 7:data[31:24].
//   Byte held stable until accepted; on accept idx++; accept at idx=7 -> RECV,
//   idx=0, out_valid_o=0 next cycle. out_valid_o stays high across bytes
//   (one byte/cycle with out_rdy_i=1). out_valid_o never drops before accept.
//  RECV: on in_rdy_i, in_data_i -> shadow byte idx (idx0 = bits[7:0]); idx++.
//   Capture of 4th byte: rd_data_o updated with full word on the next edge,
//   done_o=1 that same cycle, busy_o=0, state IDLE. rd_data_o never shows
//   partial words. New req_i accepted in the done_o cycle.
//  Timeout: counter clears on entering RECV and on every in_rdy_i; increments
//   otherwise; reaching TIMEOUT -> err_o pulse 1 cycle, busy_o=0, IDLE,
//   rd_data_o unchanged. Disabled when TIMEOUT=0.
//  in_rdy_i in IDLE or SEND: byte discarded, no state effect.
//  Latency (out_rdy_i=1, reply immediate): req edge N; bytes accepted on
//   edges N+1..N+8; reply bytes on edges R..R+3; done_o high R+4..R+5 cycle.
//  done_o and err_o mutually exclusive; never both high.
// TESTING
//  1 write 0x1234<=0xDEADBEEF, out_rdy_i=1 -> stream AA 01 34 12 EF BE AD DE on
//    8 consecutive edges; reply 78 56 34 12 -> rd_data_o=0x12345678, done_o 1 cyc.
//  2 read 0x00F0, out_rdy_i toggling 1/0 -> stream AA 00 F0 00 + data bytes,
//    each byte stable while unaccepted, no byte skipped/duplicated.
//  3 TIMEOUT=8, read, send 2 reply bytes then silence -> err_o 1 cyc after 8
//    idle cycles, no done_o, rd_data_o keeps previous value, busy_o=0.
//  4 req_i pulsed during SEND and RECV -> ignored; in_rdy_i bytes during SEND
//    -> discarded; reply word unaffected.
//  5 reset_i asserted at idx=4 of SEND, then released and new request -> clean
//    restart from 8'hAA, outputs at reset values during reset, no pulses.
//  6 back-to-back: req_i held high -> second transaction starts in done_o cycle.

Source files
------------

// File: rtl/reg_cmd_master.sv
// Register-access byte protocol initiator: serialises one read/write request into
// the 8-byte command frame and assembles the 4-byte little-endian reply word.
module reg_cmd_master #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_i,
  input  logic        req_wr_i,
  input  logic [15:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rd_data_o,
  output logic [7:0]  out_data_o,
  output logic        out_valid_o,
  input  logic        out_rdy_i,
  input  logic        in_rdy_i,
  input  logic [7:0]  in_data_i
);

  typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] shadow_q, shadow_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [15:0] tmo_q, tmo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;

  function automatic logic [7:0] cmd_byte(input logic [2:0] i, input logic wr,
                                          input logic [15:0] a, input logic [31:0] d);
    case (i)
      3'd0:    cmd_byte = 8'hAA;
      3'd1:    cmd_byte = {7'b0, wr};
      3'd2:    cmd_byte = a[7:0];
      3'd3:    cmd_byte = a[15:8];
      3'd4:    cmd_byte = d[7:0];
      3'd5:    cmd_byte = d[15:8];
      3'd6:    cmd_byte = d[23:16];
      default: cmd_byte = d[31:24];
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    shadow_d    = shadow_q;
    rd_data_d   = rd_data_q;
    tmo_d       = tmo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      IDLE: begin
        if (req_i) begin
          wr_d        = req_wr_i;
          addr_d      = req_addr_i;
          data_d      = req_data_i;
          idx_d       = 3'd0;
          busy_d      = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = 8'hAA;
          state_d     = SEND;
        end
      end
      SEND: begin
        if (out_rdy_i) begin
          if (idx_q == 3'd7) begin
            idx_d       = 3'd0;
            tmo_d       = 16'd0;
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            state_d     = RECV;
          end else begin
            idx_d      = idx_q + 3'd1;
            out_data_d = cmd_byte(idx_q + 3'd1, wr_q, addr_q, data_q);
          end
        end
      end
      RECV: begin
        // idx 4 means all reply bytes are in the shadow; publish the whole word at once
        if (idx_q == 3'd4) begin
          rd_data_d = shadow_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          idx_d     = 3'd0;
          tmo_d     = 16'd0;
          state_d   = IDLE;
        end else if (in_rdy_i) begin
          // Shift in from the top so the first byte ends up in bits [7:0]
          shadow_d = {in_data_i, shadow_q[31:8]};
          idx_d    = idx_q + 3'd1;
          tmo_d    = 16'd0;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          idx_d   = 3'd0;
          tmo_d   = 16'd0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      wr_q        <= 1'b0;
      addr_q      <= 16'h0;
      data_q      <= 32'h0;
      shadow_q    <= 32'h0;
      rd_data_q   <= 32'h0;
      tmo_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      shadow_q    <= shadow_d;
      rd_data_q   <= rd_data_d;
      tmo_q       <= tmo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rd_data_o   = rd_data_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Directed bench for reg_cmd_master: command framing, handshake stalls, reply
// assembly, timeout, ignored requests, async reset abort and back-to-back requests.
module tb_reg_cmd_master;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_i;
  logic        req_wr_i;
  logic [15:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] rd_data_o;
  logic [7:0]  out_data_o;
  logic        out_valid_o;
  logic        out_rdy_i;
  logic        in_rdy_i;
  logic [7:0]  in_data_i;

  int vectors = 0;
  int miscompares = 0;

  reg_cmd_master #(.TIMEOUT(8)) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .req_wr_i   (req_wr_i),
    .req_addr_i (req_addr_i),
    .req_data_i (req_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rd_data_o  (rd_data_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_rdy_i  (out_rdy_i),
    .in_rdy_i   (in_rdy_i),
    .in_data_i  (in_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [15:0] addr, input logic [31:0] data);
    req_i      = 1'b1;
    req_wr_i   = wr;
    req_addr_i = addr;
    req_data_i = data;
    tick();
    req_i = 1'b0;
    chk("req_busy", 32'(busy_o), 32'd1);
    chk("req_valid", 32'(out_valid_o), 32'd1);
    chk("req_first_byte", 32'(out_data_o), 32'hAA);
  endtask

  // Called right after the request edge; checks every frame byte before accepting it.
  task automatic send_phase(input logic [63:0] stream, input bit stall, input bit noise);
    for (int i = 0; i < 8; i++) begin
      chk("send_valid", 32'(out_valid_o), 32'd1);
      chk("send_byte", 32'(out_data_o), 32'(stream[8*i +: 8]));
      if (stall) begin
        out_rdy_i = 1'b0;
        tick();
        chk("stall_valid", 32'(out_valid_o), 32'd1);
        chk("stall_byte", 32'(out_data_o), 32'(stream[8*i +: 8]));
      end
      if (noise) begin
        req_i     = i[0];
        in_rdy_i  = 1'b1;
        in_data_i = 8'hFF;
      end
      out_rdy_i = 1'b1;
      tick();
    end
    if (noise) begin
      req_i    = 1'b0;
      in_rdy_i = 1'b0;
    end
    chk("send_end_valid", 32'(out_valid_o), 32'd0);
    chk("send_end_busy", 32'(busy_o), 32'd1);
  endtask

  task automatic reply(input logic [31:0] word, input logic [31:0] prev, input bit noise);
    for (int i = 0; i < 4; i++) begin
      in_rdy_i  = 1'b1;
      in_data_i = word[8*i +: 8];
      if (noise) req_i = 1'b1;
      tick();
      chk("recv_no_done", 32'(done_o), 32'd0);
    end
    in_rdy_i = 1'b0;
    if (noise) req_i = 1'b0;
    chk("recv_no_partial", rd_data_o, prev);
    tick();
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("done_no_err", 32'(err_o), 32'd0);
    chk("done_busy", 32'(busy_o), 32'd0);
    chk("rd_data", rd_data_o, word);
    $display("txn done: rd_data=%h", rd_data_o);
  endtask

  initial begin
    reset_i    = 1'b1;
    req_i      = 1'b0;
    req_wr_i   = 1'b0;
    req_addr_i = 16'h0;
    req_data_i = 32'h0;
    out_rdy_i  = 1'b1;
    in_rdy_i   = 1'b0;
    in_data_i  = 8'h00;
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'h00);
    chk("rst_rd_data", rd_data_o, 32'h0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    reset_i = 1'b0;
    tick();

    // 1: write with continuous acceptance
    issue(1'b1, 16'h1234, 32'hDEADBEEF);
    send_phase(64'hDEADBEEF_123401AA, 1'b0, 1'b0);
    reply(32'h12345678, 32'h0, 1'b0);
    tick();
    chk("done_one_cycle", 32'(done_o), 32'd0);
    $display("txn 1: write 1234 <= deadbeef");

    // 2: read with out_rdy_i toggling
    issue(1'b0, 16'h00F0, 32'hCAFEF00D);
    send_phase(64'hCAFEF00D_00F000AA, 1'b1, 1'b0);
    reply(32'hA5A55A5A, 32'h12345678, 1'b0);
    tick();
    $display("txn 2: read 00f0 with stalls");

    // 3: two reply bytes then silence -> timeout after 8 idle cycles
    issue(1'b0, 16'h0042, 32'h0);
    send_phase(64'h00000000_004200AA, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      in_rdy_i  = 1'b1;
      in_data_i = 8'h11 * 8'(i + 1);
      tick();
    end
    in_rdy_i = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_not_yet", 32'(err_o), 32'd0);
    chk("tmo_still_busy", 32'(busy_o), 32'd1);
    tick();
    chk("tmo_err", 32'(err_o), 32'd1);
    chk("tmo_no_done", 32'(done_o), 32'd0);
    chk("tmo_busy", 32'(busy_o), 32'd0);
    chk("tmo_rd_kept", rd_data_o, 32'hA5A55A5A);
    tick();
    chk("tmo_err_pulse", 32'(err_o), 32'd0);
    $display("txn 3: read 0042 timed out");

    // 4: req_i and reply strobes injected while busy are ignored
    issue(1'b1, 16'h0BAD, 32'h01020304);
    send_phase(64'h01020304_0BAD01AA, 1'b0, 1'b1);
    reply(32'h0D0C0B0A, 32'hA5A55A5A, 1'b1);
    tick();
    chk("noise_no_requeue", 32'(busy_o), 32'd0);
    chk("noise_idle_valid", 32'(out_valid_o), 32'd0);
    $display("txn 4: write 0bad with noise");

    // 5: async reset in the middle of the frame
    issue(1'b0, 16'h5555, 32'h77777777);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_byte", 32'(out_data_o), 32'h77);
    reset_i = 1'b1;
    #2;
    chk("arst_valid", 32'(out_valid_o), 32'd0);
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_data", 32'(out_data_o), 32'h00);
    chk("arst_rd_data", rd_data_o, 32'h0);
    tick();
    chk("arst_hold_done", 32'(done_o), 32'd0);
    chk("arst_hold_err", 32'(err_o), 32'd0);
    reset_i = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    issue(1'b1, 16'h0001, 32'h00000000);
    send_phase(64'h00000000_000101AA, 1'b0, 1'b0);
    reply(32'h89ABCDEF, 32'h0, 1'b0);
    tick();
    $display("txn 5: reset abort then write 0001");

    // 6: req_i held high -> next transaction launched from the done cycle
    issue(1'b1, 16'h2222, 32'h33333333);
    req_i = 1'b1;
    send_phase(64'h33333333_222201AA, 1'b0, 1'b0);
    reply(32'h44556677, 32'h89ABCDEF, 1'b0);
    tick();
    req_i = 1'b0;
    chk("b2b_busy", 32'(busy_o), 32'd1);
    chk("b2b_valid", 32'(out_valid_o), 32'd1);
    chk("b2b_byte", 32'(out_data_o), 32'hAA);
    chk("b2b_done_clear", 32'(done_o), 32'd0);
    send_phase(64'h33333333_222201AA, 1'b0, 1'b0);
    reply(32'h8899AABB, 32'h44556677, 1'b0);
    tick();
    $display("txn 6: back-to-back write 2222");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
